imem_fetch_unit: RTL and testbench

//  Parametrised RISC-V instruction memory with a valid/ready fetch port, 1-cycle read latency and a one-deep output hold under backpressure.

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_fetch_unit_if.sv | 31 +++
 rtl/imem_sdp_ram.sv | 26 ++
 rtl/imem_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_imem_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction-memory fetch unit.
package imem_pkg;

   localparam int          XLEN_DEF      = 32;
   localparam int          DEPTH_LOG_DEF = 7;
   localparam logic [31:0] NOP_INST      = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PROG = 2'd2
   } state_e;

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Fetch handshake and program-load bus of the instruction memory.
// Signal names keep the block's pin names; the slave modport is the memory side.
interface imem_fetch_unit_if
   import imem_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int ADDR_W = 30
);
   logic              i_Req_Vld;
   logic              o_Req_Rdy;
   logic [ADDR_W-1:0] i_Addr;
   logic              o_Rsp_Vld;
   logic              i_Rsp_Rdy;
   logic [XLEN-1:0]   o_Inst;
   logic              o_Err;
   logic              i_Prog_En;
   logic              i_Wr_Vld;
   logic [ADDR_W-1:0] i_Wr_Addr;
   logic [XLEN-1:0]   i_Wr_Data;
   logic              o_Busy;

   modport slave (
      input  i_Req_Vld, i_Addr, i_Rsp_Rdy, i_Prog_En, i_Wr_Vld, i_Wr_Addr, i_Wr_Data,
      output o_Req_Rdy, o_Rsp_Vld, o_Inst, o_Err, o_Busy
   );

   modport master (
      output i_Req_Vld, i_Addr, i_Rsp_Rdy, i_Prog_En, i_Wr_Vld, i_Wr_Addr, i_Wr_Data,
      input  o_Req_Rdy, o_Rsp_Vld, o_Inst, o_Err, o_Busy
   );
endinterface

// File: rtl/imem_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-cycle read of the word being written returns the old contents.
module imem_sdp_ram #(
   parameter int XLEN      = 32,
   parameter int DEPTH_LOG = 7
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [DEPTH_LOG-1:0] waddr_i,
   input  logic [XLEN-1:0]      wdata_i,
   input  logic                 re_i,
   input  logic [DEPTH_LOG-1:0] raddr_i,
   output logic [XLEN-1:0]      rdata_o
);
   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with valid/ready fetch port, post-reset NOP fill and program-load mode.
// Build option IMEM_BYPASS_EN: RUN-mode writes allowed, forwarded write-first to a colliding fetch.
module imem_fetch_unit
   import imem_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int DEPTH_LOG = DEPTH_LOG_DEF,
   parameter int ADDR_W    = 30
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   imem_fetch_unit_if.slave bus
);
   // state   | meaning
   // ST_INIT | sweeping NOP_INST into every word, fetch port closed
   // ST_RUN  | serving fetches
   // ST_PROG | program load, fetch port closed, pending response drains

   localparam int              DEPTH     = 1 << DEPTH_LOG;
   localparam int              AW1       = ADDR_W + 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = AW1'(DEPTH);

   state_e                 state_q, state_d;
   logic [DEPTH_LOG-1:0]   cnt_q, cnt_d;
   logic                   rsp_vld_q, rsp_vld_d;
   logic                   err_q, err_d;
   logic                   fwd_q, fwd_d;
   logic [XLEN-1:0]        fwd_data_q, fwd_data_d;
   logic                   seen_q, seen_d;

   logic                   req_rdy, accept;
   logic                   rd_in_range, wr_in_range;
   logic                   wr_allowed, fwd_hit;
   logic                   ram_we, ram_re;
   logic [DEPTH_LOG-1:0]   ram_waddr, ram_raddr;
   logic [XLEN-1:0]        ram_wdata, ram_rdata;
   logic [XLEN-1:0]        inst;

   always_comb begin
      req_rdy     = (state_q == ST_RUN) && !bus.i_Prog_En && (!rsp_vld_q || bus.i_Rsp_Rdy);
      accept      = bus.i_Req_Vld && req_rdy;
      // compare one bit wider so the range test never wraps the address
      rd_in_range = {1'b0, bus.i_Addr} < DEPTH_EXT;
      wr_in_range = {1'b0, bus.i_Wr_Addr} < DEPTH_EXT;
`ifdef IMEM_BYPASS_EN
      wr_allowed  = (state_q == ST_PROG) || (state_q == ST_RUN);
      fwd_hit     = accept && rd_in_range && bus.i_Wr_Vld && wr_in_range
                    && (bus.i_Wr_Addr == bus.i_Addr);
`else
      wr_allowed  = (state_q == ST_PROG);
      fwd_hit     = 1'b0;
`endif
      ram_re      = accept && rd_in_range;
      ram_raddr   = bus.i_Addr[DEPTH_LOG-1:0];
      if (state_q == ST_INIT) begin
         ram_we    = 1'b1;
         ram_waddr = cnt_q;
         ram_wdata = XLEN'(NOP_INST);
      end else begin
         ram_we    = wr_allowed && bus.i_Wr_Vld && wr_in_range;
         ram_waddr = bus.i_Wr_Addr[DEPTH_LOG-1:0];
         ram_wdata = bus.i_Wr_Data;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rsp_vld_d  = rsp_vld_q;
      err_d      = err_q;
      fwd_d      = fwd_q;
      fwd_data_d = fwd_data_q;
      seen_d     = seen_q;

      unique case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = ST_RUN;
         end
         ST_RUN:  if (bus.i_Prog_En)  state_d = ST_PROG;
         ST_PROG: if (!bus.i_Prog_En) state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase

      if (accept) begin
         rsp_vld_d = 1'b1;
         err_d     = !rd_in_range;
         fwd_d     = fwd_hit;
         seen_d    = 1'b1;
         if (fwd_hit) fwd_data_d = bus.i_Wr_Data;
      end else if (bus.i_Rsp_Rdy) begin
         rsp_vld_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         rsp_vld_q  <= 1'b0;
         err_q      <= 1'b0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
         seen_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rsp_vld_q  <= rsp_vld_d;
         err_q      <= err_d;
         fwd_q      <= fwd_d;
         fwd_data_q <= fwd_data_d;
         seen_q     <= seen_d;
      end
   end

   imem_sdp_ram #(
      .XLEN      (XLEN),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_ram (
      .clk_i   (i_Clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   // RAM read register is only loaded on accept, so it doubles as the output hold
   always_comb begin
      if (!seen_q)     inst = '0;
      else if (err_q)  inst = XLEN'(NOP_INST);
      else if (fwd_q)  inst = fwd_data_q;
      else             inst = ram_rdata;
   end

   assign bus.o_Req_Rdy = req_rdy;
   assign bus.o_Rsp_Vld = rsp_vld_q;
   assign bus.o_Inst    = inst;
   assign bus.o_Err     = err_q;
   assign bus.o_Busy    = (state_q != ST_RUN);
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: directed scenarios plus a randomized fetch/program mix.
module tb_imem_fetch_unit;
   import imem_pkg::*;

   localparam int XLEN      = 32;
   localparam int DEPTH_LOG = 7;
   localparam int ADDR_W    = 30;
   localparam int DEPTH     = 128;
`ifdef IMEM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_fetch_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

   imem_fetch_unit #(
      .XLEN      (XLEN),
      .DEPTH_LOG (DEPTH_LOG),
      .ADDR_W    (ADDR_W)
   ) dut (
      .i_Clk (clk),
      .i_Rst (rst_n),
      .bus   (bus)
   );

   int              checks = 0;
   int              errors = 0;
   logic [XLEN-1:0] model_mem [DEPTH];
   logic [XLEN:0]   exp_q [$];     // {err, inst}
   bit              in_prog = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares presented responses, then applies writes and queues new accepts.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_Rsp_Vld) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got response %h, expected none (t=%0t)", bus.o_Inst, $time);
            end else begin
               chk("rsp_inst", bus.o_Inst, exp_q[0][XLEN-1:0]);
               chk("rsp_err", 32'(bus.o_Err), 32'(exp_q[0][XLEN]));
               if (bus.i_Rsp_Rdy) void'(exp_q.pop_front());
            end
         end
         if (bus.i_Wr_Vld && (in_prog || BYPASS) && (bus.i_Wr_Addr < ADDR_W'(DEPTH)))
            model_mem[bus.i_Wr_Addr[DEPTH_LOG-1:0]] = bus.i_Wr_Data;
         if (bus.i_Req_Vld && bus.o_Req_Rdy) begin
            if (bus.i_Addr < ADDR_W'(DEPTH))
               exp_q.push_back({1'b0, model_mem[bus.i_Addr[DEPTH_LOG-1:0]]});
            else
               exp_q.push_back({1'b1, NOP_INST});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.i_Req_Vld = 1'b0;
      bus.i_Addr    = '0;
      bus.i_Rsp_Rdy = 1'b0;
      bus.i_Prog_En = 1'b0;
      bus.i_Wr_Vld  = 1'b0;
      bus.i_Wr_Addr = '0;
      bus.i_Wr_Data = '0;
      in_prog       = 1'b0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP_INST;
      #2;
      chk("rst_rsp_vld", 32'(bus.o_Rsp_Vld), 32'd0);
      chk("rst_inst", bus.o_Inst, 32'd0);
      chk("rst_err", 32'(bus.o_Err), 32'd0);
      chk("rst_busy", 32'(bus.o_Busy), 32'd1);
      chk("rst_req_rdy", 32'(bus.o_Req_Rdy), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_ready();
      int n = 0;
      int busy_low = 0;
      while (n < 1000) begin
         @(negedge clk);
         if (bus.o_Req_Rdy) break;
         if (!bus.o_Busy) busy_low++;
         tick();
         n++;
      end
      chk("init_cycles", 32'(n), 32'(DEPTH));
      chk("init_busy_low", 32'(busy_low), 32'd0);
      chk("run_busy", 32'(bus.o_Busy), 32'd0);
      tick();
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] a, input bit rand_bp);
      int n = 0;
      bit acc = 1'b0;
      bus.i_Req_Vld = 1'b1;
      bus.i_Addr    = a;
      while (!acc && n < 200) begin
         if (rand_bp) bus.i_Rsp_Rdy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.o_Req_Rdy;
         tick();
         n++;
      end
      bus.i_Req_Vld = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL fetch_timeout: addr %h not accepted within %0d cycles", a, n);
      end
   endtask

   task automatic enter_prog();
      bus.i_Prog_En = 1'b1;
      tick();
      in_prog = 1'b1;
      chk("prog_busy", 32'(bus.o_Busy), 32'd1);
      chk("prog_req_rdy", 32'(bus.o_Req_Rdy), 32'd0);
   endtask

   task automatic prog_write(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
      bus.i_Wr_Vld  = 1'b1;
      bus.i_Wr_Addr = a;
      bus.i_Wr_Data = d;
      tick();
      bus.i_Wr_Vld  = 1'b0;
   endtask

   task automatic leave_prog();
      bus.i_Prog_En = 1'b0;
      in_prog       = 1'b0;
      tick();
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      int                r;
      bus.i_Req_Vld = 1'b0;
      bus.i_Addr    = '0;
      bus.i_Rsp_Rdy = 1'b0;
      bus.i_Prog_En = 1'b0;
      bus.i_Wr_Vld  = 1'b0;
      bus.i_Wr_Addr = '0;
      bus.i_Wr_Data = '0;
      @(posedge clk);
      #1;

      // fill sweep length, then every word reads NOP
      do_reset();
      wait_ready();
      bus.i_Rsp_Rdy = 1'b1;
      for (int i = 0; i < DEPTH; i++) fetch(ADDR_W'(i), 1'b0);
      tick();
      tick();

      // program load, back-to-back fetch, hold after consumption
      enter_prog();
      prog_write(30'd5, 32'h0050_0513);
      prog_write(30'd6, 32'h00a5_8633);
      leave_prog();
      fetch(30'd5, 1'b0);
      fetch(30'd6, 1'b0);
      tick();
      @(negedge clk);
      chk("idle_rsp_vld", 32'(bus.o_Rsp_Vld), 32'd0);
      chk("idle_inst_hold", bus.o_Inst, 32'h00a5_8633);
      tick();

      // backpressure hold
      bus.i_Rsp_Rdy = 1'b0;
      fetch(30'd5, 1'b0);
      repeat (4) begin
         @(negedge clk);
         chk("stall_vld", 32'(bus.o_Rsp_Vld), 32'd1);
         chk("stall_req_rdy", 32'(bus.o_Req_Rdy), 32'd0);
         chk("stall_inst", bus.o_Inst, 32'h0050_0513);
         tick();
      end
      bus.i_Rsp_Rdy = 1'b1;
      fetch(30'd6, 1'b0);
      tick();

      // out-of-range fetches
      fetch(30'd128, 1'b0);
      fetch(30'h3FFF_FFFF, 1'b0);
      fetch(30'd5, 1'b0);
      tick();
      tick();

      // randomized mix
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70) begin
            if ($urandom_range(0, 9) == 0) a = ADDR_W'($urandom);
            else                           a = ADDR_W'($urandom_range(0, DEPTH - 1));
            fetch(a, 1'b1);
         end else if (r < 90) begin
            bus.i_Rsp_Rdy = 1'($urandom_range(0, 1));
            tick();
         end else begin
            bus.i_Rsp_Rdy = 1'b1;
            enter_prog();
            repeat ($urandom_range(1, 6)) begin
               if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom);
               else                           a = ADDR_W'($urandom_range(0, DEPTH - 1));
               prog_write(a, $urandom);
            end
            leave_prog();
         end
      end
      bus.i_Rsp_Rdy = 1'b1;
      repeat (3) tick();
      chk("random_drained", 32'(exp_q.size()), 32'd0);

      // PROG entered with a stalled response, then reset mid-PROG
      bus.i_Rsp_Rdy = 1'b0;
      fetch(30'd5, 1'b0);
      bus.i_Prog_En = 1'b1;
      tick();
      in_prog = 1'b1;
      @(negedge clk);
      chk("prog_pend_vld", 32'(bus.o_Rsp_Vld), 32'd1);
      chk("prog_pend_rdy", 32'(bus.o_Req_Rdy), 32'd0);
      tick();
      bus.i_Rsp_Rdy = 1'b1;
      tick();
      @(negedge clk);
      chk("prog_drained_vld", 32'(bus.o_Rsp_Vld), 32'd0);
      chk("prog_drained_rdy", 32'(bus.o_Req_Rdy), 32'd0);
      tick();
      prog_write(30'd5, 32'h1111_1111);
      prog_write(30'd7, 32'h2222_2222);
      do_reset();
      wait_ready();
      bus.i_Rsp_Rdy = 1'b1;
      fetch(30'd5, 1'b0);
      chk("reset_lost_prog", bus.o_Inst, NOP_INST);
      tick();
      tick();

      // same-cycle write and fetch in RUN
      enter_prog();
      prog_write(30'd9, 32'h1234_5678);
      leave_prog();
      bus.i_Wr_Vld  = 1'b1;
      bus.i_Wr_Addr = 30'd9;
      bus.i_Wr_Data = 32'hDEAD_BEEF;
      fetch(30'd9, 1'b0);
      bus.i_Wr_Vld  = 1'b0;
      chk("same_cycle_fetch", bus.o_Inst, BYPASS ? 32'hDEAD_BEEF : 32'h1234_5678);
      fetch(30'd9, 1'b0);
      tick();
      tick();
      chk("final_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: run still active at %0t, limit 1000000", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
